// File: rtl/bpf_pkg.sv
// bpf_pkg: shared class codes, instruction layout and fetch FSM encoding
package bpf_pkg;
    localparam logic [2:0] BPF_RET = 3'b110;
    localparam logic [2:0] BPF_JMP = 3'b101;
    localparam logic [3:0] BPF_JA  = 4'h0;

    typedef struct packed {
        logic [15:0] code;
        logic [7:0]  jt;
        logic [7:0]  jf;
        logic [31:0] k;
    } ir_t;

    typedef enum logic [2:0] {
        S_HALT,
        S_ADDR,
        S_DATA,
        S_DEC,
        S_NEXT
    } state_t;
endpackage

// File: rtl/bpf_next_pc.sv
// bpf_next_pc: combinational next-PC selection and PC fault detection
module bpf_next_pc
    import bpf_pkg::*;
#(
    parameter int PC_W     = 10,
    parameter int PROG_LEN = 1024
) (
    input  logic [PC_W-1:0] pc_i,
    input  ir_t             ir_i,
    input  logic            cond_i,
    output logic [PC_W-1:0] next_pc_o,
    output logic            halt_req_o,
    output logic            fault_o
);
    logic            is_jmp;
    logic            is_ja;
    logic [PC_W:0]   off;
    logic [PC_W:0]   sum;
    logic            unused_code;

    assign unused_code = ^{ir_i.code[15:8], ir_i.code[3]};

    // One extra bit on the sum catches targets past the end of program memory
    always_comb begin
        is_jmp     = ir_i.code[2:0] == BPF_JMP;
        is_ja      = is_jmp && ir_i.code[7:4] == BPF_JA;
        off        = is_ja ? {1'b0, ir_i.k[PC_W-1:0]} : is_jmp ? (PC_W+1)'(cond_i ? ir_i.jt : ir_i.jf) : '0;
        sum        = {1'b0, pc_i} + (PC_W+1)'(1) + off;
        halt_req_o = ir_i.code[2:0] == BPF_RET;
        fault_o    = !halt_req_o && ((is_ja && ir_i.k[31:PC_W] != '0) || sum >= (PC_W+1)'(PROG_LEN));
        next_pc_o  = sum[PC_W-1:0];
    end
endmodule

// File: rtl/bpf_fetch.sv
// bpf_fetch: four-step instruction fetch/sequencing stage owning the PC
module bpf_fetch
    import bpf_pkg::*;
#(
    parameter int PC_W     = 10,
    parameter int PROG_LEN = 1024
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iSTEP1,
    input  logic            iSTEP2,
    input  logic            iSTEP3,
    input  logic            iSTEP4,
    input  logic            iSTART,
    input  logic            iCOND,
    output logic [PC_W-1:0] oIMEM_ADDR,
    output logic            oIMEM_RD,
    input  logic [63:0]     iIMEM_DATA,
    output logic [15:0]     oOPCODE,
    output logic [7:0]      oJT,
    output logic [7:0]      oJF,
    output logic [31:0]     oK,
    output logic            oDEC_VALID,
    output logic [PC_W-1:0] oPC,
    output logic            oHALT,
    output logic            oFAULT
);
    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    ir_t             ir_q, ir_d;
    logic            rd_q, rd_d;
    logic            dv_q, dv_d;
    logic            fault_q, fault_d;
    logic [PC_W-1:0] next_pc;
    logic            halt_req;
    logic            pc_fault;

    bpf_next_pc #(.PC_W(PC_W), .PROG_LEN(PROG_LEN)) u_next_pc (
        .pc_i       (pc_q),
        .ir_i       (ir_q),
        .cond_i     (iCOND),
        .next_pc_o  (next_pc),
        .halt_req_o (halt_req),
        .fault_o    (pc_fault)
    );

    // Step pulses only advance the FSM when they match the current state
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        rd_d    = 1'b0;
        dv_d    = dv_q;
        fault_d = fault_q;
        case (state_q)
            S_HALT: if (iSTART) begin
                pc_d    = '0;
                fault_d = 1'b0;
                state_d = S_ADDR;
            end
            S_ADDR: if (iSTEP1) begin
                addr_d  = pc_q;
                rd_d    = 1'b1;
                dv_d    = 1'b0;
                state_d = S_DATA;
            end
            S_DATA: if (iSTEP2) begin
                ir_d    = iIMEM_DATA;
                state_d = S_DEC;
            end
            S_DEC: if (iSTEP3) begin
                dv_d    = 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT: if (iSTEP4) begin
                state_d = (halt_req || pc_fault) ? S_HALT : S_ADDR;
                fault_d = pc_fault;
                pc_d    = (halt_req || pc_fault) ? pc_q : next_pc;
            end
            default: state_d = S_HALT;
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= S_HALT;
            pc_q    <= '0;
            addr_q  <= '0;
            ir_q    <= '0;
            rd_q    <= 1'b0;
            dv_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            rd_q    <= rd_d;
            dv_q    <= dv_d;
            fault_q <= fault_d;
        end
    end

    assign oIMEM_ADDR = addr_q;
    assign oIMEM_RD   = rd_q;
    assign oOPCODE    = ir_q.code;
    assign oJT        = ir_q.jt;
    assign oJF        = ir_q.jf;
    assign oK         = ir_q.k;
    assign oDEC_VALID = dv_q;
    assign oPC        = pc_q;
    assign oHALT      = state_q == S_HALT;
    assign oFAULT     = fault_q;
endmodule

// File: tb/tb_bpf_fetch.sv
// tb_bpf_fetch: table vectors, corner sequences and random programs against a reference model
module tb_bpf_fetch;
    localparam int PC_W     = 10;
    localparam int PROG_LEN = 1024;

    logic            iCLK = 1'b0;
    logic            iRST;
    logic [3:0]      stp;
    logic            iSTART;
    logic            iCOND;
    logic [PC_W-1:0] oIMEM_ADDR;
    logic            oIMEM_RD;
    logic [63:0]     iIMEM_DATA;
    logic [15:0]     oOPCODE;
    logic [7:0]      oJT;
    logic [7:0]      oJF;
    logic [31:0]     oK;
    logic            oDEC_VALID;
    logic [PC_W-1:0] oPC;
    logic            oHALT;
    logic            oFAULT;

    logic [63:0] mem [0:PROG_LEN-1];

    int  tests = 0;
    int  failed = 0;
    int  m_pc;
    bit  m_halt;
    bit  m_fault;
    bit  rnd_gap = 0;

    typedef struct {
        logic [63:0] ins;
        int          pc;
        bit          cond;
        int          epc;
        bit          eh;
        bit          ef;
    } vec_t;

    vec_t vt [10];

    always #5 iCLK = ~iCLK;

    assign iIMEM_DATA = mem[oIMEM_ADDR];

    bpf_fetch #(.PC_W(PC_W), .PROG_LEN(PROG_LEN)) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iSTEP1     (stp[0]),
        .iSTEP2     (stp[1]),
        .iSTEP3     (stp[2]),
        .iSTEP4     (stp[3]),
        .iSTART     (iSTART),
        .iCOND      (iCOND),
        .oIMEM_ADDR (oIMEM_ADDR),
        .oIMEM_RD   (oIMEM_RD),
        .iIMEM_DATA (iIMEM_DATA),
        .oOPCODE    (oOPCODE),
        .oJT        (oJT),
        .oJF        (oJF),
        .oK         (oK),
        .oDEC_VALID (oDEC_VALID),
        .oPC        (oPC),
        .oHALT      (oHALT),
        .oFAULT     (oFAULT)
    );

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, a, e, $time);
        end
    endtask

    task automatic tick;
        @(posedge iCLK);
        #1;
    endtask

    task automatic pulse(input int s);
        stp = 4'b0001 << (s - 1);
        tick();
        stp = 4'b0000;
    endtask

    task automatic gap;
        if (rnd_gap) repeat ($urandom_range(0, 2)) tick();
    endtask

    // Instruction-level semantics: where does the program go after this instruction
    task automatic ref_step(input int pc, input logic [63:0] ins, input bit c,
                            output int npc, output bit h, output bit f);
        logic [15:0] code;
        longint      tgt;
        code = ins[63:48];
        h = 1'b0;
        f = 1'b0;
        npc = pc;
        if (code[2:0] == 3'b110) begin
            h = 1'b1;
        end else begin
            tgt = longint'(pc) + 1;
            if (code[2:0] == 3'b101)
                tgt += (code[7:4] == 4'h0) ? longint'(ins[31:0]) : longint'(c ? ins[47:40] : ins[39:32]);
            if (tgt >= PROG_LEN) begin
                h = 1'b1;
                f = 1'b1;
            end else begin
                npc = int'(tgt);
            end
        end
    endtask

    task automatic do_reset;
        iRST = 1'b0;
        tick();
        tick();
        iRST = 1'b1;
        tick();
        m_pc = 0;
        m_halt = 1;
        m_fault = 0;
    endtask

    task automatic start;
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        m_pc = 0;
        m_halt = 0;
        m_fault = 0;
        chk("start_halt", oHALT, 0);
        chk("start_fault", oFAULT, 0);
    endtask

    task automatic run_instr(input bit c);
        logic [63:0] ins;
        int          npc;
        bit          h;
        bit          f;
        ins = mem[m_pc];
        pulse(1);
        chk("rd_s1", oIMEM_RD, 1);
        chk("addr_s1", oIMEM_ADDR, 64'(m_pc));
        chk("dv_s1", oDEC_VALID, 0);
        chk("halt_run", oHALT, 0);
        gap();
        pulse(2);
        chk("rd_oneshot", oIMEM_RD, 0);
        gap();
        pulse(3);
        chk("dv_s3", oDEC_VALID, 1);
        chk("ir", {oOPCODE, oJT, oJF, oK}, ins);
        gap();
        iCOND = c;
        pulse(4);
        iCOND = $urandom_range(0, 1);
        ref_step(m_pc, ins, c, npc, h, f);
        m_pc = npc;
        m_halt = h;
        m_fault = f;
        chk("pc_s4", oPC, 64'(m_pc));
        chk("halt_s4", oHALT, 64'(m_halt));
        chk("fault_s4", oFAULT, 64'(m_fault));
        chk("dv_s4", oDEC_VALID, 1);
    endtask

    function automatic logic [63:0] rand_ins;
        int          r;
        logic [15:0] code;
        logic [2:0]  cls [6];
        cls = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        r = $urandom_range(0, 9);
        if (r == 0) return {16'h0006, 48'({$urandom, $urandom})};
        if (r <= 2) return {16'h0005, 16'({$urandom}), ($urandom_range(0, 15) == 0) ? 32'($urandom) : 32'($urandom_range(0, 20))};
        if (r <= 4) begin
            code = {8'($urandom), 4'($urandom_range(1, 15)), 1'b0, 3'b101};
            return {code, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 32'($urandom)};
        end
        code = {13'($urandom), cls[$urandom_range(0, 5)]};
        return {code, 48'({$urandom, $urandom})};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        iRST = 1'b0;
        stp = 4'b0000;
        iSTART = 1'b0;
        iCOND = 1'b0;
        for (int i = 0; i < PROG_LEN; i++) mem[i] = rand_ins();

        vt[0] = '{64'h0005_0000_0000_0005, 3,    1'b0, 9,    1'b0, 1'b0};
        vt[1] = '{64'h0015_0200_0000_0000, 4,    1'b1, 7,    1'b0, 1'b0};
        vt[2] = '{64'h0015_0200_0000_0000, 4,    1'b0, 5,    1'b0, 1'b0};
        vt[3] = '{64'h0005_0000_0001_0000, 3,    1'b0, 3,    1'b1, 1'b1};
        vt[4] = '{64'h0025_FF00_0000_0000, 1000, 1'b1, 1000, 1'b1, 1'b1};
        vt[5] = '{64'h0000_0000_0000_0000, 1023, 1'b0, 1023, 1'b1, 1'b1};
        vt[6] = '{64'h0006_0000_0000_0000, 1023, 1'b0, 1023, 1'b1, 1'b0};
        vt[7] = '{64'h0004_0000_0000_0007, 10,   1'b1, 11,   1'b0, 1'b0};
        vt[8] = '{64'h0005_0000_0000_03FF, 0,    1'b0, 0,    1'b1, 1'b1};
        vt[9] = '{64'h0045_0103_0000_0000, 20,   1'b0, 24,   1'b0, 1'b0};

        // Reset values
        tick();
        chk("rst_halt", oHALT, 1);
        chk("rst_fault", oFAULT, 0);
        chk("rst_pc", oPC, 0);
        chk("rst_rd", oIMEM_RD, 0);
        chk("rst_addr", oIMEM_ADDR, 0);
        chk("rst_dv", oDEC_VALID, 0);
        chk("rst_ir", {oOPCODE, oJT, oJF, oK}, 0);
        iRST = 1'b1;
        tick();
        m_pc = 0;
        m_halt = 1;
        m_fault = 0;

        // Steps while halted are ignored
        for (int s = 1; s <= 4; s++) begin
            pulse(s);
            chk("halt_step_rd", oIMEM_RD, 0);
            chk("halt_step_halt", oHALT, 1);
        end

        // LD, LD, RET
        mem[0] = 64'h0000_0000_0000_0001;
        mem[1] = 64'h0000_0000_0000_0002;
        mem[2] = 64'h0006_0000_0000_0000;
        start();
        for (int i = 0; i < 3; i++) run_instr(1'b0);
        chk("prog_halt", oHALT, 1);
        chk("prog_pc", oPC, 2);
        chk("prog_fault", oFAULT, 0);

        // Start coinciding with iSTEP1 in halt, out-of-order steps, start while running
        stp = 4'b0001;
        iSTART = 1'b1;
        tick();
        stp = 4'b0000;
        iSTART = 1'b0;
        m_pc = 0;
        m_halt = 0;
        chk("start_step_rd", oIMEM_RD, 0);
        chk("start_step_halt", oHALT, 0);
        pulse(3);
        chk("ooo_rd", oIMEM_RD, 0);
        chk("ooo_dv", oDEC_VALID, 1);
        pulse(4);
        pulse(2);
        chk("ooo_pc", oPC, 0);
        run_instr(1'b0);
        iSTART = 1'b1;
        tick();
        iSTART = 1'b0;
        chk("run_start_pc", oPC, 1);
        chk("run_start_halt", oHALT, 0);
        run_instr(1'b0);

        // Asynchronous reset while decoded
        start();
        pulse(1);
        pulse(2);
        pulse(3);
        chk("pre_rst_dv", oDEC_VALID, 1);
        #2 iRST = 1'b0;
        #1;
        chk("arst_dv", oDEC_VALID, 0);
        chk("arst_halt", oHALT, 1);
        chk("arst_rd", oIMEM_RD, 0);
        tick();
        iRST = 1'b1;
        tick();
        for (int s = 1; s <= 4; s++) begin
            pulse(s);
            chk("post_rst_rd", oIMEM_RD, 0);
            chk("post_rst_halt", oHALT, 1);
        end
        m_pc = 0;
        m_halt = 1;
        m_fault = 0;

        // Table-driven single-instruction vectors
        for (int v = 0; v < 10; v++) begin
            do_reset();
            if (vt[v].pc > 0) mem[0] = {16'h0005, 16'h0000, 32'(vt[v].pc - 1)};
            mem[vt[v].pc] = vt[v].ins;
            start();
            if (vt[v].pc > 0) run_instr(1'b0);
            run_instr(vt[v].cond);
            chk($sformatf("vec%0d_pc", v), oPC, 64'(vt[v].epc));
            chk($sformatf("vec%0d_halt", v), oHALT, 64'(vt[v].eh));
            chk($sformatf("vec%0d_fault", v), oFAULT, 64'(vt[v].ef));
            if (vt[v].ef) start();
        end

        // Random programs with gaps, stray steps and restarts
        do_reset();
        for (int i = 0; i < PROG_LEN; i++) mem[i] = rand_ins();
        rnd_gap = 1;
        for (int n = 0; n < 400; n++) begin
            if (m_halt) begin
                if ($urandom_range(0, 3) == 0) pulse($urandom_range(1, 4));
                start();
            end
            if ($urandom_range(0, 3) == 0) begin
                pulse($urandom_range(2, 4));
                chk("stray_rd", oIMEM_RD, 0);
                chk("stray_pc", oPC, 64'(m_pc));
            end
            run_instr(1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/bpf_fetch.md
# bpf_fetch

Instruction fetch/sequencing stage of the BPF core, directly downstream of the four-phase step generator. Consumes the one-hot step pulses iSTEP1..iSTEP4 and owns the program counter. Fetches 64-bit classic-BPF instructions from instruction memory and presents decoded fields to the execute stage. Resolves jumps and RET at the end of each instruction cycle.

## Interface
- PC_W, 10: program-counter width; instruction-memory word address.
- PROG_LEN, 1024: number of valid instructions; addresses ≥ PROG_LEN are out of range.

Ports:
- iCLK  in  1  core clock
- iRST  in  1  reset, asynchronous, active-low
- iSTEP1..iSTEP4  in  1 each  one-cycle step pulses, strictly cyclic 1→2→3→4
- iSTART  in  1  one-cycle pulse; start program at PC 0
- iCOND  in  1  conditional-jump result from ALU, sampled with iSTEP4
- oIMEM_ADDR  out  PC_W  instruction address
- oIMEM_RD  out  1  read strobe
- iIMEM_DATA  in  64  instruction word {code[63:48], jt[47:40], jf[39:32], k[31:0]}
- oOPCODE  out  16, oJT  out  8, oJF  out  8, oK  out  32  fields of the latched instruction register (IR)
- oDEC_VALID  out  1  decoded fields valid for execute
- oPC  out  PC_W  PC of the current instruction
- oHALT  out  1  core halted
- oFAULT  out  1  sticky program-counter fault

## Operation
- FSM states: S_HALT, S_ADDR, S_DATA, S_DEC, S_NEXT. Step pulses that do not match the current state are ignored.
- S_HALT: an iSTART pulse sets PC=0, clears oFAULT and goes to S_ADDR. Steps are ignored in this state.
- S_ADDR, on iSTEP1: oIMEM_ADDR=PC, oIMEM_RD=1 for exactly one cycle, oDEC_VALID=0. Next state S_DATA.
- S_DATA, on iSTEP2: IR ← iIMEM_DATA. Next state S_DEC.
- S_DEC, on iSTEP3: oDEC_VALID=1. Next state S_NEXT.
- S_NEXT, on iSTEP4: next-PC selection by class = code[2:0]:
  - 3'b110 (RET): enter S_HALT, PC unchanged.
  - 3'b101 with code[7:4]==0 (JA): PC+1+k.
  - 3'b101 otherwise: PC+1+(iCOND ? jt : jf).
  - all others: PC+1.
  - If no fault, next state is S_ADDR.
- Next-PC arithmetic is done in PC_W+1 bits with offsets zero-extended. Fault conditions:
  - JA with k[31:PC_W]≠0;
  - next PC ≥ PROG_LEN (this includes falling off the end).
  - On a fault: oFAULT=1, enter S_HALT, PC unchanged.
- oHALT = (state==S_HALT).
- iSTART while not in S_HALT is ignored. If iSTART coincides with a step pulse in S_HALT, the start is taken and the step is ignored.

## Timing
- All outputs are registered. An event sampled at edge E is visible after E.
- Reset values (asynchronous, iRST=0): state S_HALT, PC=0, IR=0, oIMEM_RD=0, oIMEM_ADDR=0, oDEC_VALID=0, oHALT=1, oFAULT=0.
- oIMEM_RD rises the cycle after the iSTEP1 edge. iIMEM_DATA is sampled at the iSTEP2 edge, one cycle later, so the memory must be single-cycle (asynchronous) read.
- oDEC_VALID is high from the iSTEP3 edge until the next iSTEP1 edge. oOPCODE, oJT, oJF and oK stay stable throughout.
- PC updates at the iSTEP4 edge. Each instruction takes exactly 4 steps; there is no overlap.
- Reset asserted mid-instruction aborts immediately. After reset release the block stays halted until iSTART.

## Structure
- Shared package bpf_pkg holds:
  - class codes (BPF_RET=3'b110, BPF_JMP=3'b101), BPF_JA op field 4'h0;
  - IR field bit positions;
  - FSM state encoding.
- Sub-module bpf_next_pc: combinational next-PC and fault computation. Inputs PC, IR, iCOND. Outputs next_pc, halt_req, fault.

## Test plan
- Reset, then iSTART, then program {LD, LD, RET} → oIMEM_ADDR 0,1,2 on successive iSTEP1; oHALT=1 after the third iSTEP4; PC=2.
- JA with k=5 at PC 3 → next fetch address 9.
- JEQ jt=2 jf=0 at PC 4: iCOND=1 → next fetch 7; iCOND=0 → next fetch 5.
- JA k=0x0001_0000, or a jump target ≥ PROG_LEN, or a non-RET instruction at PC=PROG_LEN-1 → oFAULT=1, oHALT=1, PC unchanged.
- iRST low during S_DEC → oDEC_VALID=0, oHALT=1 asynchronously; iSTEP pulses ignored until iSTART; iSTART while running has no effect.
- Out-of-order step pulse (iSTEP3 in S_ADDR) → no state change, oIMEM_RD stays 0.
